// File: rtl/wb_stage_buf.sv
// Writeback stage: DEPTH-entry in-order retire queue with register-file write,
// debug trace port and youngest-first forwarding lookups. `WS_TRACE_BP_EN enables trace backpressure.
module wb_stage_buf #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2,
  parameter int NUM_RD = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       ws_allowin,
  input  logic                       ms_to_ws_valid,
  input  logic [DATA_W/8-1:0]        ms_we,
  input  logic [ADDR_W-1:0]          ms_dest,
  input  logic [DATA_W-1:0]          ms_result,
  input  logic [31:0]                ms_pc,
  input  logic                       debug_ready,
  output logic [DATA_W/8-1:0]        rf_we,
  output logic [ADDR_W-1:0]          rf_waddr,
  output logic [DATA_W-1:0]          rf_wdata,
  output logic [31:0]                debug_wb_pc,
  output logic [DATA_W/8-1:0]        debug_wb_rf_wen,
  output logic [ADDR_W-1:0]          debug_wb_rf_wnum,
  output logic [DATA_W-1:0]          debug_wb_rf_wdata,
  input  logic [NUM_RD*ADDR_W-1:0]   ds_rs_addr,
  output logic [NUM_RD-1:0]          ds_rs_hit,
  output logic [NUM_RD-1:0]          ds_rs_partial,
  output logic [NUM_RD*DATA_W-1:0]   ds_rs_data
);

  localparam int WB = DATA_W / 8;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int unsigned DEPTH_U = DEPTH;

  typedef logic [PW-1:0] ptr_t;

  logic [WB-1:0]     we_q     [DEPTH];
  logic [ADDR_W-1:0] dest_q   [DEPTH];
  logic [DATA_W-1:0] result_q [DEPTH];
  logic [31:0]       pc_q     [DEPTH];

  ptr_t          wr_ptr;
  ptr_t          rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          retire;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  assign ws_allowin = (count < CW'(DEPTH));
  assign push       = ms_to_ws_valid && ws_allowin;

`ifdef WS_TRACE_BP_EN
  assign retire = (count != '0) && debug_ready;
`else
  logic unused_debug_ready;
  assign unused_debug_ready = debug_ready;
  assign retire = (count != '0);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= ptr_inc(wr_ptr);
      if (retire) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, retire})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // Storage needs no reset: every read is qualified by count.
  always_ff @(posedge clk) begin
    if (push) begin
      we_q[wr_ptr]     <= ms_we;
      dest_q[wr_ptr]   <= ms_dest;
      result_q[wr_ptr] <= ms_result;
      pc_q[wr_ptr]     <= ms_pc;
    end
  end

  always_comb begin
    rf_we             = '0;
    rf_waddr          = '0;
    rf_wdata          = '0;
    debug_wb_pc       = '0;
    debug_wb_rf_wen   = '0;
    debug_wb_rf_wnum  = '0;
    debug_wb_rf_wdata = '0;
    if (retire) begin
      rf_we             = we_q[rd_ptr];
      rf_waddr          = dest_q[rd_ptr];
      rf_wdata          = result_q[rd_ptr];
      debug_wb_pc       = pc_q[rd_ptr];
      debug_wb_rf_wen   = we_q[rd_ptr];
      debug_wb_rf_wnum  = dest_q[rd_ptr];
      debug_wb_rf_wdata = result_q[rd_ptr];
    end
  end

  // Scan oldest to youngest; a later match overwrites, so the youngest wins.
  always_comb begin
    logic [ADDR_W-1:0] la;
    logic              found;
    logic [WB-1:0]     fwe;
    logic [DATA_W-1:0] fres;
    int unsigned       idx;
    ptr_t              slot;
    ds_rs_hit     = '0;
    ds_rs_partial = '0;
    ds_rs_data    = '0;
    la    = '0;
    found = 1'b0;
    fwe   = '0;
    fres  = '0;
    idx   = 0;
    slot  = '0;
    for (int unsigned p = 0; p < NUM_RD; p++) begin
      la    = ds_rs_addr[p*ADDR_W +: ADDR_W];
      found = 1'b0;
      fwe   = '0;
      fres  = '0;
      for (int unsigned k = 0; k < DEPTH_U; k++) begin
        idx = 32'(rd_ptr) + k;
        if (idx >= DEPTH_U) idx = idx - DEPTH_U;
        slot = ptr_t'(idx);
        if ((k < 32'(count)) && (we_q[slot] != '0) &&
            (dest_q[slot] == la) && (la != '0)) begin
          found = 1'b1;
          fwe   = we_q[slot];
          fres  = result_q[slot];
        end
      end
      ds_rs_hit[p]     = found && (&fwe);
      ds_rs_partial[p] = found && !(&fwe);
      ds_rs_data[p*DATA_W +: DATA_W] = (found && (&fwe)) ? fres : '0;
    end
  end

endmodule

// File: tb/tb_wb_stage_buf.sv
// Scoreboard bench for wb_stage_buf: stimulus pushes accepted entries into a
// queue model; a negedge monitor pops on retire and checks trace, rf and lookups.
module tb_wb_stage_buf;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 3;
  localparam int NUM_RD = 2;

`ifdef WS_TRACE_BP_EN
  localparam bit BP = 1'b1;
`else
  localparam bit BP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        ws_allowin;
  logic        ms_to_ws_valid;
  logic [3:0]  ms_we;
  logic [4:0]  ms_dest;
  logic [31:0] ms_result;
  logic [31:0] ms_pc;
  logic        debug_ready;
  logic [3:0]  rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
  logic [9:0]  ds_rs_addr;
  logic [1:0]  ds_rs_hit;
  logic [1:0]  ds_rs_partial;
  logic [63:0] ds_rs_data;

  always #5 clk = ~clk;

  wb_stage_buf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .NUM_RD(NUM_RD)) dut (
    .clk(clk), .reset(reset), .ws_allowin(ws_allowin),
    .ms_to_ws_valid(ms_to_ws_valid), .ms_we(ms_we), .ms_dest(ms_dest),
    .ms_result(ms_result), .ms_pc(ms_pc), .debug_ready(debug_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata),
    .ds_rs_addr(ds_rs_addr), .ds_rs_hit(ds_rs_hit),
    .ds_rs_partial(ds_rs_partial), .ds_rs_data(ds_rs_data)
  );

  typedef struct {
    logic [3:0]  we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [31:0] pc;
  } ent_t;

  ent_t q[$];
  int   total = 0;
  int   bad   = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic ent_t mk(input logic [3:0] we, input logic [4:0] dest,
                              input logic [31:0] res, input logic [31:0] pc);
    ent_t e;
    e.we = we; e.dest = dest; e.result = res; e.pc = pc;
    return e;
  endfunction

  always @(negedge clk) begin
    ent_t        h;
    bit          ret;
    bit          found;
    logic [4:0]  a;
    logic [3:0]  fw;
    logic [31:0] fr;
    if (mon_en) begin
      chk("allowin", 64'(ws_allowin), 64'(q.size() < DEPTH));
      for (int p = 0; p < NUM_RD; p++) begin
        a = ds_rs_addr[p*5 +: 5];
        found = 1'b0; fw = '0; fr = '0;
        for (int i = q.size() - 1; i >= 0 && !found; i--) begin
          if (q[i].we != 4'h0 && q[i].dest == a && a != 5'd0) begin
            found = 1'b1; fw = q[i].we; fr = q[i].result;
          end
        end
        chk($sformatf("hit%0d", p), 64'(ds_rs_hit[p]), 64'(found && fw == 4'hF));
        chk($sformatf("partial%0d", p), 64'(ds_rs_partial[p]), 64'(found && fw != 4'hF));
        chk($sformatf("fwd_data%0d", p), 64'(ds_rs_data[p*32 +: 32]),
            64'((found && fw == 4'hF) ? fr : 32'h0));
      end
      ret = (q.size() != 0) && (!BP || debug_ready);
      if (ret) h = q.pop_front();
      else h = mk(4'h0, 5'd0, 32'h0, 32'h0);
      chk("rf_we", 64'(rf_we), 64'(h.we));
      if (ret) begin
        chk("rf_waddr", 64'(rf_waddr), 64'(h.dest));
        chk("rf_wdata", 64'(rf_wdata), 64'(h.result));
      end
      chk("wb_pc", 64'(debug_wb_pc), 64'(h.pc));
      chk("wb_wen", 64'(debug_wb_rf_wen), 64'(h.we));
      chk("wb_wnum", 64'(debug_wb_rf_wnum), 64'(h.dest));
      chk("wb_wdata", 64'(debug_wb_rf_wdata), 64'(h.result));
    end
  end

  // One cycle: drive inputs, predict acceptance from the model, update it at the edge.
  task automatic cyc(input bit rst, input bit v, input ent_t e, input bit rdy,
                     input logic [4:0] a0, input logic [4:0] a1, output bit acc);
    reset = rst; ms_to_ws_valid = v;
    ms_we = e.we; ms_dest = e.dest; ms_result = e.result; ms_pc = e.pc;
    debug_ready = rdy; ds_rs_addr = {a1, a0};
    acc = v && (q.size() < DEPTH);
    @(posedge clk);
    if (rst) q.delete();
    else if (acc) q.push_back(e);
    #1;
  endtask

  task automatic idle(input int n, input bit rdy, input logic [4:0] a0, input logic [4:0] a1);
    bit acc;
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, mk(4'h0, 5'd0, 32'h0, 32'h0), rdy, a0, a1, acc);
  endtask

  // Memory stage holds an entry until accepted, bounded by a cycle budget.
  task automatic send(input ent_t e, input bit rdy, input logic [4:0] a0, input logic [4:0] a1,
                      input int budget);
    bit acc;
    acc = 1'b0;
    for (int i = 0; i < budget && !acc; i++) cyc(1'b0, 1'b1, e, rdy, a0, a1, acc);
  endtask

  initial begin
    bit   acc;
    bit   pend;
    ent_t cur;
    int   r;
    cyc(1'b1, 1'b0, mk(4'h0, 5'd0, 32'h0, 32'h0), 1'b0, 5'd0, 5'd0, acc);
    mon_en = 1'b1;
    cyc(1'b1, 1'b1, mk(4'hF, 5'd1, 32'h1, 32'h1), 1'b1, 5'd1, 5'd0, acc);

    send(mk(4'hF, 5'd5, 32'h1234_5678, 32'hBFC0_0000), 1'b1, 5'd5, 5'd0, 1);
    idle(2, 1'b1, 5'd5, 5'd0);

    for (int i = 0; i < 5; i++) begin
      cur = mk(4'hF, 5'(i + 1), 32'h100 + 32'(i), 32'hBFC0_1000 + 32'(i * 4));
      cyc(1'b0, 1'b1, cur, 1'b0, 5'd1, 5'd2, acc);
      if (!acc) send(cur, 1'b1, 5'd2, 5'd3, 4);
    end
    idle(5, 1'b1, 5'd3, 5'd4);

    send(mk(4'hF, 5'd3, 32'hA, 32'h200), 1'b0, 5'd3, 5'd0, 4);
    send(mk(4'hF, 5'd3, 32'hB, 32'h204), 1'b0, 5'd3, 5'd0, 4);
    idle(1, 1'b0, 5'd3, 5'd0);
    idle(4, 1'b1, 5'd3, 5'd0);

    send(mk(4'b0011, 5'd7, 32'h77, 32'h300), 1'b0, 5'd7, 5'd7, 4);
    idle(1, 1'b0, 5'd7, 5'd0);
    send(mk(4'hF, 5'd7, 32'hC, 32'h304), 1'b0, 5'd7, 5'd7, 4);
    idle(1, 1'b0, 5'd7, 5'd0);
    idle(4, 1'b1, 5'd7, 5'd0);

    for (int i = 0; i < 10; i++)
      send(mk(4'hF, 5'(i + 8), 32'hD000 + 32'(i), 32'h400 + 32'(i * 4)), 1'b1, 5'(i + 7), 5'd0, 4);
    idle(4, 1'b1, 5'd0, 5'd0);

    send(mk(4'hF, 5'd9, 32'h91, 32'h500), 1'b0, 5'd9, 5'd0, 4);
    send(mk(4'hF, 5'd10, 32'h92, 32'h504), 1'b0, 5'd9, 5'd10, 4);
    cyc(1'b1, 1'b1, mk(4'hF, 5'd11, 32'h93, 32'h508), 1'b0, 5'd9, 5'd10, acc);
    idle(2, 1'b1, 5'd9, 5'd10);

    pend = 1'b0;
    for (int c = 0; c < 800; c++) begin
      if (!pend) begin
        r = $urandom % 4;
        cur = mk((r == 0) ? 4'h0 : (r == 3) ? 4'($urandom_range(1, 14)) : 4'hF,
                 5'($urandom % 8), $urandom, $urandom);
        pend = ($urandom % 4) != 0;
      end
      cyc(($urandom % 150) == 0, pend, cur, ($urandom % 10) < 7,
          5'($urandom % 8), 5'($urandom % 8), acc);
      if (acc || reset) pend = 1'b0;
    end
    idle(8, 1'b1, 5'd0, 5'd0);

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
